// File: rtl/cfb_dec_chain_ctrl.sv
// ---------------------------------------------------------------------------
// cfb_dec_chain_ctrl
//   Sequential front end for a combinational AES-128 CFB decrypt core.
//   This block registers the key, the chaining IV and one ciphertext block,
//   and holds them on the core inputs. It waits a fixed number of cycles for
//   the core to settle, captures the core output and presents it on a
//   valid/ready stream. After each block, the ciphertext just consumed
//   becomes the next IV (CFB chaining).
//
// Ports
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_key_in, i_iv_in     key and initial IV, sampled on i_iv_load
//   i_iv_load             start a new message (accepted only in IDLE)
//   i_in_valid/o_in_ready ciphertext input handshake, data on i_in_data
//   o_core_key/iv/image   registered, stable inputs to the core
//   i_core_result         core output (plaintext)
//   o_out_valid/i_out_ready plaintext output handshake, data on o_out_data
//   o_busy                high whenever the FSM is not in IDLE
//   o_blk_count           blocks delivered since the last i_iv_load (wraps)
// ---------------------------------------------------------------------------
module cfb_dec_chain_ctrl #(
    parameter int unsigned CORE_LAT = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [127:0]     i_key_in,
    input  logic [127:0]     i_iv_in,
    input  logic             i_iv_load,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [127:0]     i_in_data,
    output logic [127:0]     o_core_key,
    output logic [127:0]     o_core_iv,
    output logic [127:0]     o_core_image,
    input  logic [127:0]     i_core_result,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [127:0]     o_out_data,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_blk_count
);

    localparam int unsigned WAIT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StOut
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [WAIT_W-1:0] r_cnt;
    logic [WAIT_W-1:0] w_cnt_next;
    logic [127:0]      r_key;
    logic [127:0]      w_key_next;
    logic [127:0]      r_iv;
    logic [127:0]      w_iv_next;
    logic [127:0]      r_image;
    logic [127:0]      w_image_next;
    logic [127:0]      r_out_data;
    logic [127:0]      w_out_data_next;
    logic              r_out_valid;
    logic              w_out_valid_next;
    logic [CNT_W-1:0]  r_blk_count;
    logic [CNT_W-1:0]  w_blk_count_next;
    logic              w_in_ready;

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_key_next       = r_key;
        w_iv_next        = r_iv;
        w_image_next     = r_image;
        w_out_data_next  = r_out_data;
        w_out_valid_next = r_out_valid;
        w_blk_count_next = r_blk_count;
        // iv_load takes priority over a simultaneous block in IDLE
        w_in_ready       = (r_state == StIdle) && !i_iv_load;

        unique case (r_state)
            StIdle: begin
                if (i_iv_load) begin
                    w_key_next       = i_key_in;
                    w_iv_next        = i_iv_in;
                    w_blk_count_next = '0;
                end else if (i_in_valid) begin
                    w_image_next = i_in_data;
                    w_cnt_next   = WAIT_W'(CORE_LAT - 1);
                    w_state_next = StWait;
                end
            end
            StWait: begin
                // Core inputs are frozen here; the core gets CORE_LAT cycles to settle.
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - WAIT_W'(1);
                end else begin
                    w_out_data_next  = i_core_result;
                    w_iv_next        = r_image;
                    w_out_valid_next = 1'b1;
                    w_state_next     = StOut;
                end
            end
            StOut: begin
                if (i_out_ready) begin
                    w_out_valid_next = 1'b0;
                    w_blk_count_next = r_blk_count + CNT_W'(1);
                    w_state_next     = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_key       <= '0;
            r_iv        <= '0;
            r_image     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_blk_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_key       <= w_key_next;
            r_iv        <= w_iv_next;
            r_image     <= w_image_next;
            r_out_data  <= w_out_data_next;
            r_out_valid <= w_out_valid_next;
            r_blk_count <= w_blk_count_next;
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_core_key   = r_key;
    assign o_core_iv    = r_iv;
    assign o_core_image = r_image;
    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;
    assign o_busy       = (r_state != StIdle);
    assign o_blk_count  = r_blk_count;

endmodule

// File: tb/tb_cfb_dec_chain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cfb_dec_chain_ctrl
//   Directed bench for cfb_dec_chain_ctrl. The AES core is stood in for by a
//   combinational stub that returns image ^ keystream, where the keystream
//   for the two SP800-38A CFB128 blocks is derived from the published vectors
//   and any other IV gets an arbitrary but deterministic keystream.
// ---------------------------------------------------------------------------
module tb_cfb_dec_chain_ctrl;

    localparam int unsigned CORE_LAT = 4;
    localparam int unsigned CNT_W    = 32;

    localparam logic [127:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
    localparam logic [127:0] PT1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT2  = 128'hc8a64537a0b3a93fcde3cdad9f1ce58b;
    localparam logic [127:0] PT2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CT3  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] JUNK = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    logic             clk = 1'b0;
    logic             rst;
    logic [127:0]     key_in;
    logic [127:0]     iv_in;
    logic             iv_load;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic [127:0]     core_key;
    logic [127:0]     core_iv;
    logic [127:0]     core_image;
    logic [127:0]     core_result;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic             busy;
    logic [CNT_W-1:0] blk_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cfb_dec_chain_ctrl #(
        .CORE_LAT(CORE_LAT),
        .CNT_W   (CNT_W)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_key_in     (key_in),
        .i_iv_in      (iv_in),
        .i_iv_load    (iv_load),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_data    (in_data),
        .o_core_key   (core_key),
        .o_core_iv    (core_iv),
        .o_core_image (core_image),
        .i_core_result(core_result),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_busy       (busy),
        .o_blk_count  (blk_count)
    );

    // Keystream for any IV outside the known vectors: rotated key ^ iv.
    function automatic logic [127:0] ks_other(input logic [127:0] k, input logic [127:0] iv);
        return iv ^ {k[63:0], k[127:64]};
    endfunction

    always_comb begin
        if (core_iv == IV0)      core_result = core_image ^ (PT1 ^ CT1);
        else if (core_iv == CT1) core_result = core_image ^ (PT2 ^ CT2);
        else                     core_result = core_image ^ ks_other(core_key, core_iv);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // All stimulus changes happen at the negative edge.
    task automatic load_iv(input logic [127:0] k, input logic [127:0] iv);
        @(negedge clk);
        key_in  = k;
        iv_in   = iv;
        iv_load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv_load = 1'b0;
    endtask

    // Accept one block and wait for out_valid; returns observed latency.
    // wait_iv_load pulses iv_load with junk during WAIT; rst_at_wait resets mid-WAIT.
    task automatic send_block(input string tag, input logic [127:0] ct,
                              input logic [127:0] exp_iv_wait, input bit wait_iv_load,
                              input bit rst_at_wait, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        in_data  = ct;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = JUNK;
        lat = 0;
        check({tag, "_iv_wait"}, core_iv, exp_iv_wait);
        if (wait_iv_load) begin
            key_in  = JUNK;
            iv_in   = JUNK;
            iv_load = 1'b1;
        end
        if (rst_at_wait) rst = 1'b1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            iv_load = 1'b0;
            rst     = 1'b0;
            lat++;
        end
    endtask

    task automatic take_output;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [127:0] held;
        bit          stable;
        bit          seen;

        rst       = 1'b1;
        key_in    = '0;
        iv_in     = '0;
        iv_load   = 1'b0;
        in_valid  = 1'b1;
        in_data   = JUNK;
        out_ready = 1'b0;

        // T1 reset with in_valid asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check("t1_out_valid", 128'(out_valid), 128'(0));
        check("t1_busy", 128'(busy), 128'(0));
        check("t1_blk_count", 128'(blk_count), 128'(0));
        check("t1_out_data", out_data, 128'(0));
        check("t1_in_ready", 128'(in_ready), 128'(1));
        check("t1_core_iv", core_iv, 128'(0));

        // T2 first SP800-38A block
        load_iv(KEY, IV0);
        check("t2_core_key", core_key, KEY);
        check("t2_core_iv", core_iv, IV0);
        send_block("t2", CT1, IV0, 1'b0, 1'b0, lat);
        check("t2_latency", 128'(lat), 128'(CORE_LAT));
        check("t2_out_data", out_data, PT1);
        check("t2_chain_iv", core_iv, CT1);
        check("t2_in_ready_out", 128'(in_ready), 128'(0));
        check("t2_busy", 128'(busy), 128'(1));
        take_output();
        check("t2_blk_count", 128'(blk_count), 128'(1));
        check("t2_idle", 128'(busy), 128'(0));

        // T3 chained second block
        send_block("t3", CT2, CT1, 1'b0, 1'b0, lat);
        check("t3_latency", 128'(lat), 128'(CORE_LAT));
        check("t3_out_data", out_data, PT2);
        take_output();
        check("t3_blk_count", 128'(blk_count), 128'(2));

        // T4 backpressure with in_valid pushed during OUT
        send_block("t4", CT3, CT2, 1'b0, 1'b0, lat);
        check("t4_out_data", out_data, CT3 ^ ks_other(KEY, CT2));
        held     = out_data;
        stable   = 1'b1;
        in_valid = 1'b1;
        in_data  = JUNK;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || out_data !== held || in_ready || core_image !== CT3) stable = 1'b0;
        end
        in_valid = 1'b0;
        check("t4_stable", 128'(stable), 128'(1));
        check("t4_blk_hold", 128'(blk_count), 128'(2));
        take_output();
        check("t4_blk_count", 128'(blk_count), 128'(3));
        @(negedge clk);
        check("t4_no_accept", 128'(busy), 128'(0));

        // T5 iv_load vs in_valid in IDLE, then iv_load during WAIT
        key_in   = KEY;
        iv_in    = IV0;
        iv_load  = 1'b1;
        in_valid = 1'b1;
        in_data  = JUNK;
        #1;
        check("t5_in_ready_conflict", 128'(in_ready), 128'(0));
        @(posedge clk);
        @(negedge clk);
        iv_load  = 1'b0;
        in_valid = 1'b0;
        check("t5_no_accept", 128'(busy), 128'(0));
        check("t5_iv_reload", core_iv, IV0);
        check("t5_blk_clear", 128'(blk_count), 128'(0));
        send_block("t5", CT1, IV0, 1'b1, 1'b0, lat);
        check("t5_out_data", out_data, PT1);
        check("t5_key_kept", core_key, KEY);
        take_output();

        // T6 reset during WAIT
        send_block("t6", CT2, CT1, 1'b0, 1'b1, lat);
        check("t6_core_iv", core_iv, 128'(0));
        check("t6_busy", 128'(busy), 128'(0));
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("t6_no_valid", 128'(seen), 128'(0));
        load_iv(KEY, IV0);
        send_block("t6r", CT1, IV0, 1'b0, 1'b0, lat);
        check("t6r_latency", 128'(lat), 128'(CORE_LAT));
        check("t6r_out_data", out_data, PT1);
        take_output();
        check("t6r_blk_count", 128'(blk_count), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
